// File: rtl/alu_issue_ctrl_if.sv
// Command and response channels between the control unit and
// the ALU issue controller.
interface alu_issue_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_opcode;
  logic [15:0] cmd_op1;
  logic [15:0] cmd_op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_we;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_we, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_we, rsp_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: sequences one op at a time into the ALU,
// returns a registered response and owns the Z/N/C/V flags.
module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus,
  output logic            alu_enable,
  output logic [5:0]      opcode,
  output logic [15:0]     term1,
  output logic [15:0]     term2,
  input  logic [15:0]     result,
  input  logic            fl_zero,
  input  logic            fl_negative,
  input  logic            done,
  output logic [3:0]      flags
);
  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_DIV = 6'h03;
  localparam logic [5:0] OP_MOD = 6'h04;
  localparam logic [5:0] OP_CMP = 6'h09;
  localparam logic [5:0] OP_TST = 6'h0F;
  localparam logic [5:0] OP_INC = 6'h10;
  localparam logic [5:0] OP_DEC = 6'h11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic        en_d;
  logic [5:0]  op_d;
  logic [15:0] t1_d, t2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rv_q, rv_d;
  logic [15:0] rr_q, rr_d;
  logic        rwe_q, rwe_d;
  logic        rerr_q, rerr_d;
  logic [3:0]  fl_d;

  logic        div_zero;
  logic        is_add, is_sub, no_wb;
  logic [15:0] b_op;
  logic [16:0] sum, diff;
  logic [1:0]  cv;

  assign div_zero = ((bus.cmd_opcode == OP_DIV) ||
                     (bus.cmd_opcode == OP_MOD)) &&
                    (bus.cmd_op2 == 16'h0000);

  // INC/DEC reuse the add/sub carry rules with an implicit 1
  assign is_add = (opcode == OP_ADD) || (opcode == OP_INC);
  assign is_sub = (opcode == OP_SUB) || (opcode == OP_CMP) ||
                  (opcode == OP_DEC);
  assign no_wb  = (opcode == OP_CMP) || (opcode == OP_TST);
  assign b_op   = ((opcode == OP_INC) || (opcode == OP_DEC)) ?
                  16'd1 : term2;
  assign sum    = {1'b0, term1} + {1'b0, b_op};
  assign diff   = {1'b0, term1} - {1'b0, b_op};

  always_comb begin
    cv = 2'b00;
    unique case (1'b1)
      is_add: cv = {sum[16],
                    (term1[15] == b_op[15]) && (sum[15] != term1[15])};
      is_sub: cv = {diff[16],
                    (term1[15] != b_op[15]) && (diff[15] != term1[15])};
      default: cv = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    en_d    = alu_enable;
    op_d    = opcode;
    t1_d    = term1;
    t2_d    = term2;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    rr_d    = rr_q;
    rwe_d   = rwe_q;
    rerr_d  = rerr_q;
    fl_d    = flags;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_opcode;
          t1_d = bus.cmd_op1;
          t2_d = bus.cmd_op2;
          if (div_zero) begin
            rv_d    = 1'b1;
            rr_d    = 16'hFFFF;
            rwe_d   = 1'b0;
            rerr_d  = 1'b1;
            state_d = RESP;
          end else begin
            en_d    = 1'b1;
            cnt_d   = 8'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (done) begin
          en_d    = 1'b0;
          rv_d    = 1'b1;
          rr_d    = result;
          rwe_d   = ~no_wb;
          rerr_d  = 1'b0;
          fl_d    = {fl_zero, fl_negative, cv};
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          en_d    = 1'b0;
          rv_d    = 1'b1;
          rr_d    = 16'hFFFF;
          rwe_d   = 1'b0;
          rerr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_enable <= 1'b0;
      opcode     <= 6'h00;
      term1      <= 16'h0000;
      term2      <= 16'h0000;
      cnt_q      <= 8'd0;
      rv_q       <= 1'b0;
      rr_q       <= 16'h0000;
      rwe_q      <= 1'b0;
      rerr_q     <= 1'b0;
      flags      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      alu_enable <= en_d;
      opcode     <= op_d;
      term1      <= t1_d;
      term2      <= t2_d;
      cnt_q      <= cnt_d;
      rv_q       <= rv_d;
      rr_q       <= rr_d;
      rwe_q      <= rwe_d;
      rerr_q     <= rerr_d;
      flags      <= fl_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = rv_q;
  assign bus.rsp_result = rr_q;
  assign bus.rsp_we     = rwe_q;
  assign bus.rsp_err    = rerr_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction timeline model plus a
// behavioural ALU, checked every cycle, with literal anchors.
module tb_alu_issue_ctrl;
  localparam int TO = 8;
  localparam logic [5:0] ADD = 6'h00;
  localparam logic [5:0] SUB = 6'h01;
  localparam logic [5:0] MUL = 6'h02;
  localparam logic [5:0] DIV = 6'h03;
  localparam logic [5:0] MOD = 6'h04;
  localparam logic [5:0] CMP = 6'h09;
  localparam logic [5:0] TST = 6'h0F;
  localparam logic [5:0] INC = 6'h10;
  localparam logic [5:0] DEC = 6'h11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_issue_ctrl_if bus ();
  logic        alu_enable;
  logic [5:0]  opcode;
  logic [15:0] term1, term2, result, fv;
  logic        fl_zero, fl_negative, done;
  logic [3:0]  flags;

  int cyc = 0;
  int done_at = 0;
  int ready_at = 0;
  bit done_en = 1'b0;
  bit stray = 1'b0;

  alu_issue_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_enable(alu_enable), .opcode(opcode),
    .term1(term1), .term2(term2), .result(result),
    .fl_zero(fl_zero), .fl_negative(fl_negative),
    .done(done), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu_res(input logic [5:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      ADD: return a + b;
      SUB: return a - b;
      MUL: return a * b;
      DIV: return (b == 16'h0) ? 16'hFFFF : a / b;
      MOD: return (b == 16'h0) ? 16'hFFFF : a % b;
      INC: return a + 16'd1;
      DEC: return a - 16'd1;
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] alu_fv(input logic [5:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      CMP: return a - b;
      TST: return a & b;
      default: return alu_res(op, a, b);
    endcase
  endfunction

  assign result      = alu_res(opcode, term1, term2);
  assign fv          = alu_fv(opcode, term1, term2);
  assign fl_zero     = (fv == 16'h0000);
  assign fl_negative = fv[15];
  assign done        = (alu_enable && done_en && (cyc >= done_at)) || stray;
  assign bus.rsp_ready = (cyc >= ready_at);

  function automatic logic [3:0] exp_flags(input logic [5:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    int ua, ub, sa, sb, s;
    bit c, v;
    logic [15:0] f;
    f  = alu_fv(op, a, b);
    ua = int'(a);
    sa = int'($signed(a));
    ub = (op == INC || op == DEC) ? 1 : int'(b);
    sb = (op == INC || op == DEC) ? 1 : int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    if (op == ADD || op == INC) begin
      c = (ua + ub) > 65535;
      s = sa + sb;
      v = (s > 32767) || (s < -32768);
    end else if (op == SUB || op == CMP || op == DEC) begin
      c = ua < ub;
      s = sa - sb;
      v = (s > 32767) || (s < -32768);
    end
    return {f == 16'h0000, f[15], c, v};
  endfunction

  int mE = 0, mV = 0, mH = 0;
  bit m_en = 1'b0;
  logic [5:0]  m_op = '0, m_op_p = '0;
  logic [15:0] m_t1 = '0, m_t1_p = '0, m_t2 = '0, m_t2_p = '0;
  logic [15:0] m_res = '0;
  bit          m_we = 1'b0, m_err = 1'b0;
  logic [3:0]  m_fold = '0, m_fnew = '0;
  int last_e = 0, en_before = 0;

  int en_total = 0;
  int v_rise = 0;
  logic pv = 1'b0;
  logic [15:0] cap_res = '0;
  logic cap_we = 1'b0, cap_err = 1'b0;
  logic [3:0] cap_flags = '0;

  always @(negedge clk) begin
    if (rst) begin
      pv <= 1'b0;
    end else begin
      if (alu_enable) en_total <= en_total + 1;
      pv <= bus.rsp_valid;
      if (bus.rsp_valid && !pv) begin
        v_rise    <= cyc;
        cap_res   <= bus.rsp_result;
        cap_we    <= bus.rsp_we;
        cap_err   <= bus.rsp_err;
        cap_flags <= flags;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_loop();
    int n;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n = cyc;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(!(n >= mE && n < mH)));
        chk("alu_enable", 32'(alu_enable), 32'(m_en && n >= mE && n < mV));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(n >= mV && n < mH));
        chk("flags", 32'(flags), 32'((n >= mV) ? m_fnew : m_fold));
        chk("opcode", 32'(opcode), 32'((n >= mE) ? m_op : m_op_p));
        chk("term1", 32'(term1), 32'((n >= mE) ? m_t1 : m_t1_p));
        chk("term2", 32'(term2), 32'((n >= mE) ? m_t2 : m_t2_p));
        if (n >= mV && n < mH) begin
          chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
          chk("rsp_we", 32'(bus.rsp_we), 32'(m_we));
          chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
        end
      end
    end
  endtask

  // d: cycles of ISSUE before done (negative = never); r: stall cycles
  task automatic issue(input logic [5:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int d, input int r);
    bit z2, ok;
    int e, v;
    z2 = (op == DIV || op == MOD) && (b == 16'h0000);
    ok = !z2 && d >= 0 && d <= TO - 1;
    e  = cyc + 1;
    v  = z2 ? e : (ok ? e + 1 + d : e + TO);
    m_op_p = m_op; m_t1_p = m_t1; m_t2_p = m_t2;
    m_op = op; m_t1 = a; m_t2 = b;
    m_fold = m_fnew;
    if (ok) begin
      m_res  = alu_res(op, a, b);
      m_we   = !(op == CMP || op == TST);
      m_err  = 1'b0;
      m_fnew = exp_flags(op, a, b);
    end else begin
      m_res = 16'hFFFF;
      m_we  = 1'b0;
      m_err = 1'b1;
    end
    mE = e; mV = v; mH = v + 1 + r; m_en = !z2;
    done_en = ok; done_at = e + d; ready_at = v + r;
    en_before = en_total; last_e = e;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_op1    = a;
    bus.cmd_op2    = b;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int d, input int r);
    issue(op, a, b, d, r);
    repeat (mH - last_e) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_op1    = '0;
    bus.cmd_op2    = '0;
    fork
      cmp_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_alu_enable", 32'(alu_enable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_rsp_we_err", 32'({bus.rsp_we, bus.rsp_err}), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_terms", 32'({opcode, term1}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(ADD, 16'h7FFF, 16'h0001, 0, 0);
    chk("add_res", 32'(cap_res), 32'h8000);
    chk("add_we", 32'(cap_we), 32'd1);
    chk("add_flags", 32'(cap_flags), 32'b0101);
    chk("add_en_cycles", 32'(en_total - en_before), 32'd1);
    chk("add_latency", 32'(v_rise + 1 - last_e), 32'd2);

    run_op(CMP, 16'h0003, 16'h0005, 0, 0);
    chk("cmp_res", 32'(cap_res), 32'h0003);
    chk("cmp_we", 32'(cap_we), 32'd0);
    chk("cmp_flags", 32'(cap_flags), 32'b0110);

    run_op(DIV, 16'h0010, 16'h0000, 0, 0);
    chk("div0_err", 32'(cap_err), 32'd1);
    chk("div0_res", 32'(cap_res), 32'hFFFF);
    chk("div0_flags", 32'(cap_flags), 32'b0110);
    chk("div0_en_cycles", 32'(en_total - en_before), 32'd0);
    chk("div0_latency", 32'(v_rise + 1 - last_e), 32'd1);

    run_op(ADD, 16'h0001, 16'h0001, -1, 0);
    chk("tmo_en_cycles", 32'(en_total - en_before), 32'd8);
    chk("tmo_err_we", 32'({cap_err, cap_we}), 32'b10);
    chk("tmo_flags", 32'(cap_flags), 32'b0110);

    run_op(ADD, 16'h0001, 16'h0001, 0, 0);
    chk("add2_flags", 32'(cap_flags), 32'b0000);

    run_op(SUB, 16'h0000, 16'h0001, 0, 5);
    chk("sub_res", 32'(cap_res), 32'hFFFF);
    chk("sub_flags", 32'(cap_flags), 32'b0110);

    run_op(INC, 16'hFFFF, 16'h0000, 2, 0);
    chk("inc_res", 32'(cap_res), 32'h0000);
    chk("inc_flags", 32'(cap_flags), 32'b1010);
    chk("inc_latency", 32'(v_rise + 1 - last_e), 32'd4);

    run_op(DEC, 16'h8000, 16'h0000, 0, 1);
    chk("dec_res", 32'(cap_res), 32'h7FFF);
    chk("dec_flags", 32'(cap_flags), 32'b0001);

    run_op(MOD, 16'h0007, 16'h0000, 0, 0);
    chk("mod0_err", 32'(cap_err), 32'd1);

    run_op(MOD, 16'h0007, 16'h0003, 0, 0);
    chk("mod_res", 32'(cap_res), 32'h0001);
    chk("mod_flags", 32'(cap_flags), 32'b0000);

    run_op(TST, 16'h8001, 16'h8000, 0, 0);
    chk("tst_we", 32'(cap_we), 32'd0);
    chk("tst_flags", 32'(cap_flags), 32'b0100);

    run_op(6'h20, 16'h1234, 16'h0005, 0, 0);
    chk("unk_res_we", 32'({cap_res, cap_we}), 32'({16'h1234, 1'b1}));

    run_op(MUL, 16'h0003, 16'h0004, TO - 1, 0);
    chk("mul_late_res", 32'({cap_res, cap_err}), 32'({16'h000C, 1'b0}));
    chk("mul_late_en", 32'(en_total - en_before), 32'd8);

    stray = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stray = 1'b0;

    run_op(ADD, 16'h8000, 16'h8000, 0, 0);
    chk("addcv_flags", 32'(cap_flags), 32'b1011);

    issue(ADD, 16'h0101, 16'h0202, -1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mE = 0; mV = 0; mH = 0; m_en = 1'b0;
    m_op = '0; m_op_p = '0; m_t1 = '0; m_t1_p = '0;
    m_t2 = '0; m_t2_p = '0; m_fold = '0; m_fnew = '0;
    done_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_enable", 32'(alu_enable), 32'd0);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(ADD, 16'h0002, 16'h0003, 0, 0);
    chk("post_rst_res", 32'(cap_res), 32'h0005);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
